// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises (DATA_W+2)-bit command frames from MOSI and
// streams the RAM's read byte back on MISO after a read-data frame.
module spi_slave_if #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
);

  localparam int unsigned FRAME_W = DATA_W + 2;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
  localparam int unsigned TXC_W   = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [FRAME_W-2:0]  shreg;
  logic                rd_addr_seen;
  logic                armed;
  logic [DATA_W-1:0]   tx_shift;
  logic [TXC_W-1:0]    tx_cnt;

  logic                cmd_bit;
  logic                frame_bit;
  logic                frame_done;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (SS_n) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = CHK_CMD;
        CHK_CMD: begin
          if (!MOSI)             state_nxt = WRITE;
          else if (rd_addr_seen) state_nxt = READ_DATA;
          else                   state_nxt = READ_ADD;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    cmd_bit    = 1'b0;
    frame_bit  = 1'b0;
    frame_done = 1'b0;
    if (!SS_n) begin
      cmd_bit = (state == CHK_CMD);
      if ((state == WRITE || state == READ_ADD || state == READ_DATA) &&
          (cnt < CNT_W'(FRAME_W))) begin
        frame_bit  = 1'b1;
        frame_done = (cnt == CNT_W'(FRAME_W - 1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      MISO         <= 1'b0;
      rx_valid     <= 1'b0;
      rx_data      <= '0;
      cnt          <= '0;
      shreg        <= '0;
      rd_addr_seen <= 1'b0;
      armed        <= 1'b0;
      tx_shift     <= '0;
      tx_cnt       <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (SS_n) begin
        // Abort or inter-frame gap: rx_data and rd_addr_seen deliberately keep their values.
        cnt      <= '0;
        armed    <= 1'b0;
        tx_shift <= '0;
        tx_cnt   <= '0;
        MISO     <= 1'b0;
      end else begin
        if (cmd_bit) begin
          shreg <= {{(FRAME_W-2){1'b0}}, MOSI};
          cnt   <= CNT_W'(1);
        end
        if (frame_bit) begin
          shreg <= {shreg[FRAME_W-3:0], MOSI};
          cnt   <= cnt + CNT_W'(1);
        end

        if (armed && tx_valid) begin
          MISO     <= tx_data[DATA_W-1];
          tx_shift <= {tx_data[DATA_W-2:0], 1'b0};
          tx_cnt   <= TXC_W'(DATA_W - 1);
          armed    <= 1'b0;
        end else if (tx_cnt != '0) begin
          MISO     <= tx_shift[DATA_W-1];
          tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
          tx_cnt   <= tx_cnt - TXC_W'(1);
        end else begin
          MISO <= 1'b0;
        end

        if (frame_done) begin
          rx_data  <= {shreg, MOSI};
          rx_valid <= 1'b1;
          if (state == READ_ADD) rd_addr_seen <= 1'b1;
          if (state == READ_DATA) begin
            rd_addr_seen <= 1'b0;
            armed        <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: write, read, abort, stale tx_valid and reset cases.
module tb_spi_slave_if;

  logic       clk = 1'b0;
  logic       rst;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned vld_cnt  = 0;
  int unsigned dbl_cnt  = 0;
  logic        prev_vld = 1'b0;

  spi_slave_if #(.DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) vld_cnt++;
    if (rx_valid === 1'b1 && prev_vld) dbl_cnt++;
    prev_vld = (rx_valid === 1'b1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full frame: E0..E10 shift-in, E11..E18 MISO byte capture, E19/E20 trailing MISO.
  task automatic send_frame(input logic [9:0] f, input logic give_tx, input logic [7:0] txd,
                            output logic [7:0] mb, output logic pre, output logic post);
    pre  = 1'b0;
    post = 1'b0;
    mb   = '0;
    SS_n = 1'b0;
    MOSI = 1'b0;
    tick();
    pre |= MISO;
    for (int i = 9; i >= 0; i--) begin
      MOSI = f[i];
      tick();
      pre |= MISO;
    end
    check_eq("rx_valid_after_E10", 32'(rx_valid), 32'd1);
    check_eq("rx_data_frame", 32'(rx_data), 32'(f));
    if (give_tx) begin
      tx_valid = 1'b1;
      tx_data  = txd;
    end
    for (int b = 7; b >= 0; b--) begin
      tick();
      mb[b] = MISO;
    end
    if (give_tx) tx_valid = 1'b0;
    tick();
    post |= MISO;
    tick();
    post |= MISO;
    SS_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [7:0]  mb;
    logic        pre;
    logic        post;
    int unsigned v0;

    rst      = 1'b1;
    SS_n     = 1'b0;
    MOSI     = 1'b0;
    tx_data  = '0;
    tx_valid = 1'b0;

    for (int c = 0; c < 3; c++) begin
      MOSI = ~MOSI;
      tick();
      check_eq("reset_miso", 32'(MISO), 32'd0);
      check_eq("reset_rx_valid", 32'(rx_valid), 32'd0);
      check_eq("reset_rx_data", 32'(rx_data), 32'd0);
    end
    check_eq("reset_state_idle", 32'(dut.state), 32'd0);
    rst  = 1'b0;
    SS_n = 1'b1;
    tick();

    v0 = vld_cnt;
    send_frame(10'b00_1010_0101, 1'b0, 8'h00, mb, pre, post);
    check_eq("wr_addr_rx_data", 32'(rx_data), 32'h0A5);
    check_eq("wr_addr_one_pulse", vld_cnt - v0, 32'd1);

    v0 = vld_cnt;
    send_frame(10'b01_1111_0000, 1'b0, 8'h00, mb, pre, post);
    check_eq("wr_data_rx_data", 32'(rx_data), 32'h1F0);
    check_eq("wr_data_one_pulse", vld_cnt - v0, 32'd1);

    send_frame(10'h2A5, 1'b0, 8'h00, mb, pre, post);
    check_eq("rd_addr_seen_set", 32'(dut.rd_addr_seen), 32'd1);
    check_eq("rd_addr_miso_idle", 32'({pre, mb, post}), 32'd0);

    send_frame(10'h300, 1'b1, 8'hC3, mb, pre, post);
    check_eq("rd_data_miso_byte", 32'(mb), 32'hC3);
    check_eq("rd_data_miso_pre", 32'(pre), 32'd0);
    check_eq("rd_data_miso_post", 32'(post), 32'd0);
    check_eq("rd_addr_seen_clear", 32'(dut.rd_addr_seen), 32'd0);

    // Abort a write frame after six bits.
    v0   = vld_cnt;
    SS_n = 1'b0;
    MOSI = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      MOSI = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick();
    end
    SS_n = 1'b1;
    tick();
    tick();
    check_eq("abort_no_valid", vld_cnt - v0, 32'd0);
    check_eq("abort_rx_data_held", 32'(rx_data), 32'h300);
    check_eq("abort_miso", 32'(MISO), 32'd0);
    v0 = vld_cnt;
    send_frame(10'h055, 1'b0, 8'h00, mb, pre, post);
    check_eq("post_abort_rx_data", 32'(rx_data), 32'h055);
    check_eq("post_abort_one_pulse", vld_cnt - v0, 32'd1);

    // Stale tx_valid held high across a full read sequence.
    tx_valid = 1'b1;
    tx_data  = 8'h5A;
    tick();
    check_eq("stale_idle_miso", 32'(MISO), 32'd0);
    send_frame(10'h2A5, 1'b0, 8'h00, mb, pre, post);
    check_eq("stale_rd_addr_miso", 32'({pre, mb, post}), 32'd0);
    send_frame(10'h3FF, 1'b0, 8'h00, mb, pre, post);
    check_eq("stale_miso_byte", 32'(mb), 32'h5A);
    check_eq("stale_miso_pre", 32'(pre), 32'd0);
    check_eq("stale_miso_post", 32'(post), 32'd0);
    tx_valid = 1'b0;

    // Reset in the middle of a frame clears rd_addr_seen.
    send_frame(10'h2A5, 1'b0, 8'h00, mb, pre, post);
    check_eq("pre_rst_seen", 32'(dut.rd_addr_seen), 32'd1);
    SS_n = 1'b0;
    MOSI = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    check_eq("midrst_seen", 32'(dut.rd_addr_seen), 32'd0);
    check_eq("midrst_state", 32'(dut.state), 32'd0);
    check_eq("midrst_rx_data", 32'(rx_data), 32'd0);
    rst  = 1'b0;
    SS_n = 1'b1;
    tick();

    check_eq("rx_valid_never_double", dbl_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_if.md
# spi_slave_if

SPI slave front end that sits between an external SPI master and the single-port RAM command port. It deserialises 10-bit command frames from MOSI into parallel `rx_data` words with a one-cycle `rx_valid` strobe. For read-data frames it also captures the RAM's returned byte on `tx_valid` and serialises it back out on MISO. The SPI clock is the system clock (`clk`), so the whole block is single-domain.

## Interface
- `DATA_W`, default 8: payload width. The frame is `DATA_W+2` bits (2-bit opcode plus payload).
- `clk`  in  1  SPI/system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `SS_n`  in  1  slave select, active-low; frame boundary.
- `MOSI`  in  1  serial data from master, MSB first, sampled on rising edge of `clk`.
- `MISO`  out  1  serial read data to master, MSB first.
- `rx_data`  out  DATA_W+2  last complete frame; [DATA_W+1:DATA_W] is the opcode (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data).
- `rx_valid`  out  1  one-cycle strobe; `rx_data` is valid while it is high.
- `tx_data`  in  DATA_W  read byte from RAM.
- `tx_valid`  in  1  `tx_data` valid. The RAM holds it high indefinitely, so the slave treats it as a level.

## Operation
- Reset values: state IDLE; `MISO`=0, `rx_valid`=0, `rx_data`=0; bit counter 0; `rd_addr_seen` flag 0; tx-armed flag 0.
- FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
  - IDLE -> CHK_CMD when `SS_n`=0.
  - CHK_CMD: samples MOSI as frame bit 9 into the shift register and sets the counter to 1.
    - MOSI=0 -> WRITE.
    - MOSI=1 and `rd_addr_seen`=0 -> READ_ADD.
    - MOSI=1 and `rd_addr_seen`=1 -> READ_DATA.
  - WRITE / READ_ADD / READ_DATA: shift MOSI into the register once per clock until the counter reaches 10.
    - On the 10th bit: load `rx_data` with the full frame and pulse `rx_valid` for 1 cycle.
    - The counter then saturates; further MOSI bits are ignored.
  - Any state -> IDLE on the first edge with `SS_n`=1. This has priority over all other transitions.
- `rd_addr_seen`:
  - Set when a READ_ADD frame completes.
  - Cleared when a READ_DATA frame completes its 10th bit.
  - Unchanged by an aborted frame.
- Classification is by state, not by the received opcode.
  - A READ_ADD frame whose bit 8 is 1 is still forwarded unchanged; the RAM decodes the opcode.
  - The `rd_addr_seen` flag only sequences the READ_ADD/READ_DATA states.
- READ_DATA response:
  - The tx-armed flag is set on the same edge as `rx_valid`.
  - On the first edge with armed=1 and `tx_valid`=1: capture `tx_data`, drive MISO=`tx_data[7]`, clear armed.
  - The next 7 edges drive bits 6..0. MISO returns to 0 after bit 0.
  - A stale `tx_valid` that is high before armed is set is ignored.
- Abort (`SS_n` high mid-frame):
  - No `rx_valid` is issued for the partial frame.
  - Counter, armed flag and the MISO shift are cleared; MISO=0.
  - `rx_data` holds its last value.
- `rst` mid-frame returns every register to its reset value on the next edge, including `rd_addr_seen`.

## Timing
- Edge numbering: E0 is the first rising edge with `SS_n`=0 in IDLE.
- E0: IDLE -> CHK_CMD.
- E1: bit 9 is sampled.
- E2..E10: bits 8..0 are sampled.
- `rx_valid` is high in the cycle after E10, i.e. it is registered at E10.
- The master must present frame bit 9 on MOSI for the E1 sample; MOSI at E0 is don't-care.
- With the RAM's 1-cycle latency:
  - `tx_valid` is sampled at E11.
  - MISO carries bit 7 from E11 to E12, and so on; bit 0 is driven from E18 to E19.
  - The master samples MISO on E12..E19.
- Back-to-back frames: `SS_n` must be high for at least one edge between frames. E0 of the next frame is the following low edge.
- `rx_valid` is never high for 2 consecutive cycles.

## Test plan
- **Reset:** hold `rst`=1 for 3 cycles with `SS_n`=0 and MOSI toggling -> MISO=0, `rx_valid`=0, `rx_data`=0 throughout; state is IDLE after release.
- **Write-address frame:** send 10'b00_1010_0101 -> exactly one `rx_valid` pulse after E10 with `rx_data`=10'h0A5.
- **Write-data frame:** send 10'b01_1111_0000 -> `rx_data`=10'h1F0.
- **Full read sequence:**
  - Send rd-addr 10'h2A5; `rd_addr_seen` becomes 1.
  - Send rd-data 10'h300; the RAM model returns 8'hC3 with `tx_valid` at E11.
  - Expected: MISO=1,1,0,0,0,0,1,1 on E12..E19; `rd_addr_seen` is 0 afterwards.
- **Abort:** raise `SS_n` after 6 bits of a write frame -> no `rx_valid`; the next complete frame 10'h055 decodes correctly.
- **Stale `tx_valid`:** hold `tx_valid`=1 constantly with 8'h5A, then run rd-addr and rd-data frames -> MISO streams 8'h5A exactly once, starting E11. MISO=0 before E11 and after the 8th bit.
